// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the APB3 requester.
//   - default bus widths and timeout depth
//   - FSM state encoding (IDLE, SETUP, ACCESS, RESP)
//   - response codes (OKAY, SLVERR, TIMEOUT, MISALIGN) and decode helpers
package apb_pkg;

  localparam int DEF_APB_ADDR_WIDTH = 5;
  localparam int DEF_APB_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef enum logic [1:0] {
    OKAY     = 2'd0,
    SLVERR   = 2'd1,
    TIMEOUT  = 2'd2,
    MISALIGN = 2'd3
  } apb_rsp_e;

  function automatic logic rsp_is_err(input apb_rsp_e code);
    return code != OKAY;
  endfunction

  function automatic logic rsp_is_timeout(input apb_rsp_e code);
    return code == TIMEOUT;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: counts ACCESS cycles spent waiting for PREADY.
//   clk_i  in  clock
//   rst_i  in  synchronous active-high reset
//   clr_i  in  restart count at 0 (asserted in SETUP)
//   en_i   in  increment (ACCESS with PREADY low)
//   tc_o   out count == TIMEOUT_CYCLES-1; tied low when TIMEOUT_CYCLES == 0
module apb_timeout_cnt
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  // For TIMEOUT_CYCLES == 0 this value is meaningless; tc_o is gated off.
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // The FSM leaves ACCESS on the terminal count, so no wrap guard is needed.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) cnt_q <= '0;
    else if (en_i)      cnt_q <= cnt_q + 1'b1;
  end

  assign tc_o = TMO_EN && (cnt_q == LAST);

endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: APB3 requester, one transfer in flight.
//   PCLK, PRESET          clock, synchronous active-high reset
//   cmd_*                 valid/ready command in (write, byte addr, wdata)
//   rsp_*                 valid/ready response out (rdata, err, timeout)
//   PSEL..PWDATA          APB requester outputs
//   PRDATA,PREADY,PSLVERR APB completer inputs
// Misaligned commands (addr[1:0] != 0) skip the bus and answer with an error.
// A completer that never raises PREADY is cut off after TIMEOUT_CYCLES ACCESS cycles.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = DEF_APB_ADDR_WIDTH,
  parameter int APB_DATA_WIDTH = DEF_APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [APB_DATA_WIDTH-1:0] PWDATA,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  apb_state_e                state_q;
  apb_rsp_e                  rsp_code_q;
  logic                      cmd_ready_q;
  logic                      psel_q, penable_q, pwrite_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;
  logic                      rsp_valid_q;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q;
  logic                      tmo_tc;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk_i (PCLK),
    .rst_i (PRESET),
    .clr_i (state_q == SETUP),
    .en_i  ((state_q == ACCESS) && !PREADY),
    .tc_o  (tmo_tc)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_code_q  <= OKAY;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            cmd_ready_q <= 1'b0;
            if (cmd_addr_i[1:0] != 2'b00) begin
              // No bus activity at all; the APB outputs keep their old values.
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_code_q  <= MISALIGN;
            end else begin
              state_q  <= SETUP;
              psel_q   <= 1'b1;
              pwrite_q <= cmd_write_i;
              paddr_q  <= cmd_addr_i;
              pwdata_q <= cmd_wdata_i;
            end
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          // PREADY is tested first so a completion on the terminal cycle is not lost.
          if (PREADY) begin
            state_q     <= RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= (!pwrite_q && !PSLVERR) ? PRDATA : '0;
            rsp_code_q  <= PSLVERR ? SLVERR : OKAY;
          end else if (tmo_tc) begin
            state_q     <= RESP;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_code_q  <= TIMEOUT;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_code_q  <= OKAY;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_is_err(rsp_code_q);
  assign rsp_timeout_o = rsp_is_timeout(rsp_code_q);
  assign PSEL          = psel_q;
  assign PENABLE       = penable_q;
  assign PWRITE        = pwrite_q;
  assign PADDR         = paddr_q;
  assign PWDATA        = pwdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: directed bench for apb_master_ctrl with a small APB completer
// model (0x00 read-only, 0x04 read/write, programmable wait states, error and hang).
module tb_apb_master_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [31:0] RO_VAL = 32'h0000_CAFE;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;

  int checks = 0;
  int errors = 0;

  // completer model state
  int          bfm_waits = 0;
  logic        bfm_err   = 1'b0;
  logic        bfm_hang  = 1'b0;
  int          bfm_cnt   = 0;
  logic [31:0] reg4      = 32'h0;

  // per-command observations
  int          psel_at, pen_at, rsp_at, acc_n;
  logic        paddr_bad, ready_seen;

  always #5 clk = ~clk;

  apb_master_ctrl #(
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .PCLK          (clk),
    .PRESET        (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_write_i   (cmd_write),
    .cmd_addr_i    (cmd_addr),
    .cmd_wdata_i   (cmd_wdata),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .rsp_timeout_o (rsp_timeout),
    .PSEL          (psel),
    .PENABLE       (penable),
    .PWRITE        (pwrite),
    .PADDR         (paddr),
    .PWDATA        (pwdata),
    .PRDATA        (prdata),
    .PREADY        (pready),
    .PSLVERR       (pslverr)
  );

  // completer model
  assign pready  = psel && penable && !bfm_hang && (bfm_cnt == bfm_waits);
  assign pslverr = pready && bfm_err;
  assign prdata  = (paddr == 5'h00) ? RO_VAL : (paddr == 5'h04) ? reg4 : 32'h0;

  always @(posedge clk) begin
    if (psel && penable && !pready) bfm_cnt <= bfm_cnt + 1;
    else                            bfm_cnt <= 0;
    if (psel && penable && pready && pwrite && !bfm_err && paddr == 5'h04) reg4 <= pwdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one command and sample each cycle (negedge) until rsp_valid.
  // Sample index 1 is the first cycle after the accept edge.
  task automatic run_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    // junk on the command inputs must be ignored outside IDLE
    cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = 5'h1c; cmd_wdata = 32'h5555_AAAA;
    n = 1; psel_at = 0; pen_at = 0; rsp_at = 0; acc_n = 0;
    paddr_bad = 1'b0; ready_seen = 1'b0;
    while (!rsp_valid && n < 100) begin
      if (psel && psel_at == 0) psel_at = n;
      if (penable && pen_at == 0) pen_at = n;
      if (psel && penable) acc_n++;
      if (psel && paddr !== a) paddr_bad = 1'b1;
      if (cmd_ready) ready_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    if (rsp_valid) rsp_at = n;
    else chk("rsp_wait_bound", 32'd0, 32'd1);
    chk("cmd_ready_busy", {31'b0, ready_seen}, 32'd0);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
    chk("cmd_ready_back", {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    logic        stable;
    logic [31:0] s_err, s_rdata;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_outs", {25'b0, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, 1'b0}, 32'd0);
    chk("rst_paddr", {27'b0, paddr}, 32'd0);
    rst = 1'b0;

    // 1: write 0x04, zero waits
    bfm_waits = 0;
    run_cmd(1'b1, 5'h04, 32'hDEADBEEF);
    chk("t1_psel_at", psel_at, 32'd1);
    chk("t1_pen_at", pen_at, 32'd2);
    chk("t1_rsp_at", rsp_at, 32'd3);
    chk("t1_err", {30'b0, rsp_err, rsp_timeout}, 32'd0);
    chk("t1_rdata", rsp_rdata, 32'd0);
    chk("t1_reg4", reg4, 32'hDEADBEEF);
    chk("t1_pwdata_hold", pwdata, 32'hDEADBEEF);
    handshake();

    // 2: read 0x04, 3 wait states
    bfm_waits = 3;
    run_cmd(1'b0, 5'h04, 32'h1111_2222);
    chk("t2_access_n", acc_n, 32'd4);
    chk("t2_paddr_stable", {31'b0, paddr_bad}, 32'd0);
    chk("t2_rsp_at", rsp_at, 32'd6);
    chk("t2_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("t2_err", {30'b0, rsp_err, rsp_timeout}, 32'd0);
    chk("t2_reg4_kept", reg4, 32'hDEADBEEF);
    handshake();

    // 3: read 0x00 with PSLVERR
    bfm_waits = 0; bfm_err = 1'b1;
    run_cmd(1'b0, 5'h00, 32'h0);
    chk("t3_err", {31'b0, rsp_err}, 32'd1);
    chk("t3_timeout", {31'b0, rsp_timeout}, 32'd0);
    chk("t3_rdata", rsp_rdata, 32'd0);
    handshake();
    bfm_err = 1'b0;

    // 4: completer hangs -> timeout after 16 ACCESS cycles
    bfm_hang = 1'b1;
    run_cmd(1'b0, 5'h04, 32'h0);
    chk("t4_access_n", acc_n, 32'd16);
    chk("t4_psel_off", {30'b0, psel, penable}, 32'd0);
    chk("t4_err", {31'b0, rsp_err}, 32'd1);
    chk("t4_timeout", {31'b0, rsp_timeout}, 32'd1);
    chk("t4_rdata", rsp_rdata, 32'd0);
    handshake();
    bfm_hang = 1'b0;
    run_cmd(1'b0, 5'h00, 32'h0);
    chk("t4_next_rdata", rsp_rdata, RO_VAL);
    chk("t4_next_err", {30'b0, rsp_err, rsp_timeout}, 32'd0);
    handshake();

    // 5: misaligned write, then back-pressure on the response
    run_cmd(1'b1, 5'h06, 32'h0BAD_0BAD);
    chk("t5_psel_never", psel_at, 32'd0);
    chk("t5_rsp_at", rsp_at, 32'd1);
    chk("t5_err", {30'b0, rsp_err, rsp_timeout}, 32'd2);
    s_err = {30'b0, rsp_err, rsp_timeout}; s_rdata = rsp_rdata; stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!rsp_valid || cmd_ready || {30'b0, rsp_err, rsp_timeout} !== s_err || rsp_rdata !== s_rdata)
        stable = 1'b0;
    end
    chk("t5_hold_stable", {31'b0, stable}, 32'd1);
    handshake();
    chk("t5_reg4_untouched", reg4, 32'hDEADBEEF);

    // 6: reset during an ACCESS wait
    bfm_waits = 8;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'h04; cmd_wdata = 32'hFEED_F00D;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_in_access", {30'b0, psel, penable}, 32'd3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_outs", {28'b0, psel, penable, rsp_valid, cmd_ready}, 32'd1);
    chk("t6_rst_paddr", {27'b0, paddr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_no_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("t6_reg4_kept", reg4, 32'hDEADBEEF);
    bfm_waits = 0;
    run_cmd(1'b1, 5'h04, 32'h1234_5678);
    chk("t6_after_err", {30'b0, rsp_err, rsp_timeout}, 32'd0);
    chk("t6_after_rsp_at", rsp_at, 32'd3);
    chk("t6_reg4_new", reg4, 32'h1234_5678);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
